jtframe_ps2keys: RTL and testbench
==================================

// Module: jtframe_ps2keys
// PURPOSE
//  Decodes a PS/2 set-2 scan-code byte stream into held-key levels for the input stage.
//  Sits between the PS/2 byte receiver and jtframe_inputs.
//  Drives key_joy1/2, key_start, key_coin, key_service, key_test, key_pause and key_reset.
//  All outputs are active-high levels; jtframe_inputs applies edge detection and polarity.
// PARAMETERS
//  TOUT_W  16  width of prefix timeout counter; pending prefix abandoned after 2**TOUT_W-1 idle cycles
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   reset, asynchronous, active-low
//  clr          in   1   synchronous clear of all key levels and decoder state
//  ps2_valid    in   1   one-cycle strobe, ps2_byte valid
//  ps2_byte     in   8   received scan-code byte
//  key_joy1     out  10  P1 {b9..b4,up,down,left,right}
//  key_joy2     out  10  P2, same layout
//  key_start    out  4   start 1-4
//  key_coin     out  4   coin 1-4
//  key_service  out  1   service key held
//  key_test     out  1   test key held
//  key_pause    out  1   pause key held
//  key_reset    out  1   reset key held
// BEHAVIOUR
//  Reset (rst_n=0) or clr=1: all outputs 0, FSM=IDLE, skip/timeout counters 0; clr has priority over ps2_valid.
//  FSM states: IDLE, EXT (after E0), BRK (after F0), EXTBRK (E0 then F0), SKIP.
//   IDLE: E0->EXT; F0->BRK; E1->SKIP with skip count 7.
//    FA/AA/EE/FE: ignored, stay IDLE. 00/FF (overrun): clear all key levels, stay IDLE.
//    Any other byte: make of normal code, stay IDLE.
//   EXT: F0->EXTBRK; other byte: make of extended code, ->IDLE.
//   BRK: any byte: break of normal code, ->IDLE. EXTBRK: any byte: break of extended code, ->IDLE.
//   SKIP: each valid byte decrements count; at 0 ->IDLE. Pause-key sequence is swallowed, no output change.
//  Make sets the mapped bit, break clears it; unmapped codes change nothing. Repeated makes (typematic) keep bit at 1.
//  Timeout: in EXT/BRK/EXTBRK/SKIP a counter runs while ps2_valid=0 and resets on every valid byte.
//   On reaching all-ones: ->IDLE, key levels unchanged.
//  Latency: an output changes on the clk edge that samples ps2_valid with the final byte (registered outputs).
//  Normal map: 14 j1b4, 11 j1b5, 29 j1b6, 12 j1b7, 1A j1b8, 22 j1b9.
//   23 j2 right, 1C j2 left, 1B j2 down, 1D j2 up, 15 j2b4, 24 j2b5.
//   16/1E/26/25 start1-4, 2E/36/3D/3E coin1-4, 46 service, 06 test (F2), 4D pause (P), 04 reset (F3).
//  Extended map: 74 j1 right, 6B j1 left, 72 j1 down, 75 j1 up. All other extended codes ignored.
//   E0 14 is not j1b4.
//  Opposite directions may be held simultaneously; no SOCD filtering here.
//  Reset asserted mid-sequence: the partial sequence is discarded, and the next byte is decoded from IDLE.
// TESTING
//  Bytes 14, then F0 14 -> key_joy1[4]=1 after 14 byte; =0 after the F0 14 sequence completes; no other bit moves.
//  E0 75 then E0 F0 75 -> key_joy1[3] 1 then 0; key_joy2 and key_start stay 0.
//  E1 14 77 E1 F0 14 F0 77 then 16 -> outputs unchanged through the E1 sequence; key_start=4'b0001 after 16.
//  E0, then 2**TOUT_W idle cycles, then 74 -> FSM back to IDLE; 74 decoded as normal code (unmapped), key_joy1[0]=0.
//  Hold 16 and 2E, then byte 00 -> key_start=0 and key_coin=0 on the next cycle.
//  Hold 16, then clr=1 coincident with ps2_valid byte 1E -> all outputs 0; 1E ignored.
//  Hold 1C and 23 -> key_joy2[1:0]=2'b11.
//  rst_n low mid-F0 -> outputs 0; next byte 22 is a make, key_joy1[9]=1.

Source files
------------

// File: rtl/jtframe_ps2keys.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_ps2keys
//  Purpose  : PS/2 set-2 scan-code decoder producing held-key levels
//             (joysticks, start, coin, service, test, pause, reset).
//  Revision : 1.0  initial release
// ============================================================================
module jtframe_ps2keys #(
  parameter int TOUT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ps2_valid,
  input  logic [7:0] ps2_byte,
  output logic [9:0] key_joy1,
  output logic [9:0] key_joy2,
  output logic [3:0] key_start,
  output logic [3:0] key_coin,
  output logic       key_service,
  output logic       key_test,
  output logic       key_pause,
  output logic       key_reset
);

  // Decoder states; EXTBRK is the E0 F0 (extended break) prefix pair.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } state_t;

  localparam logic [TOUT_W-1:0] TOUT_MAX   = '1;
  localparam logic [TOUT_W-1:0] TOUT_ONE   = {{(TOUT_W-1){1'b0}}, 1'b1};
  // Bytes left to swallow after E1 in the 8-byte Pause sequence.
  localparam logic [2:0]        SKIP_PAUSE = 3'd7;

  // Flat key vector layout:
  //  [9:0]   joy1 {b9..b4,up,down,left,right}
  //  [19:10] joy2 same layout
  //  [23:20] start 1-4   [27:24] coin 1-4
  //  [28] service  [29] test  [30] pause  [31] reset
  logic [31:0]       keys_q, keys_d;
  state_t            state_q, state_d;
  logic [2:0]        skip_q, skip_d;
  logic [TOUT_W-1:0] tout_q, tout_d;

  logic              nrm_hit;
  logic [4:0]        nrm_idx;
  logic              ext_hit;
  logic [4:0]        ext_idx;

  // Map a non-prefixed scan code onto its key-vector bit.
  always_comb begin
    nrm_hit = 1'b1;
    nrm_idx = 5'd0;
    case (ps2_byte)
      8'h14: nrm_idx = 5'd4;
      8'h11: nrm_idx = 5'd5;
      8'h29: nrm_idx = 5'd6;
      8'h12: nrm_idx = 5'd7;
      8'h1A: nrm_idx = 5'd8;
      8'h22: nrm_idx = 5'd9;
      8'h23: nrm_idx = 5'd10;
      8'h1C: nrm_idx = 5'd11;
      8'h1B: nrm_idx = 5'd12;
      8'h1D: nrm_idx = 5'd13;
      8'h15: nrm_idx = 5'd14;
      8'h24: nrm_idx = 5'd15;
      8'h16: nrm_idx = 5'd20;
      8'h1E: nrm_idx = 5'd21;
      8'h26: nrm_idx = 5'd22;
      8'h25: nrm_idx = 5'd23;
      8'h2E: nrm_idx = 5'd24;
      8'h36: nrm_idx = 5'd25;
      8'h3D: nrm_idx = 5'd26;
      8'h3E: nrm_idx = 5'd27;
      8'h46: nrm_idx = 5'd28;
      8'h06: nrm_idx = 5'd29;
      8'h4D: nrm_idx = 5'd30;
      8'h04: nrm_idx = 5'd31;
      default: nrm_hit = 1'b0;
    endcase
  end

  // Map an E0-prefixed scan code; only the arrow cluster drives joy1.
  always_comb begin
    ext_hit = 1'b1;
    ext_idx = 5'd0;
    case (ps2_byte)
      8'h74: ext_idx = 5'd0;
      8'h6B: ext_idx = 5'd1;
      8'h72: ext_idx = 5'd2;
      8'h75: ext_idx = 5'd3;
      default: ext_hit = 1'b0;
    endcase
  end

  // Next-state logic: prefix tracking, make/break updates and prefix timeout.
  always_comb begin
    keys_d  = keys_q;
    state_d = state_q;
    skip_d  = skip_q;
    tout_d  = tout_q;
    if (clr) begin
      keys_d  = '0;
      state_d = ST_IDLE;
      skip_d  = '0;
      tout_d  = '0;
    end else if (ps2_valid) begin
      tout_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (ps2_byte)
            8'hE0: state_d = ST_EXT;
            8'hF0: state_d = ST_BRK;
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = SKIP_PAUSE;
            end
            // Keyboard replies (ACK, BAT pass, echo, resend) carry no key info.
            8'hFA, 8'hAA, 8'hEE, 8'hFE: ;
            // Buffer overrun: held state can no longer be trusted.
            8'h00, 8'hFF: keys_d = '0;
            default: if (nrm_hit) keys_d[nrm_idx] = 1'b1;
          endcase
        end
        ST_EXT: begin
          if (ps2_byte == 8'hF0) begin
            state_d = ST_EXTBRK;
          end else begin
            if (ext_hit) keys_d[ext_idx] = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (nrm_hit) keys_d[nrm_idx] = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXTBRK: begin
          if (ext_hit) keys_d[ext_idx] = 1'b0;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_q <= 3'd1) begin
            skip_d  = '0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A stalled prefix is dropped so the next byte decodes from IDLE.
      if (tout_q == TOUT_MAX) begin
        tout_d  = '0;
        skip_d  = '0;
        state_d = ST_IDLE;
      end else begin
        tout_d = tout_q + TOUT_ONE;
      end
    end
  end

  // State and key-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys_q  <= '0;
      state_q <= ST_IDLE;
      skip_q  <= '0;
      tout_q  <= '0;
    end else begin
      keys_q  <= keys_d;
      state_q <= state_d;
      skip_q  <= skip_d;
      tout_q  <= tout_d;
    end
  end

  assign key_joy1    = keys_q[9:0];
  assign key_joy2    = keys_q[19:10];
  assign key_start   = keys_q[23:20];
  assign key_coin    = keys_q[27:24];
  assign key_service = keys_q[28];
  assign key_test    = keys_q[29];
  assign key_pause   = keys_q[30];
  assign key_reset   = keys_q[31];

endmodule
`default_nettype wire

// File: tb/tb_jtframe_ps2keys.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtframe_ps2keys
//  Purpose  : Directed self-checking bench for jtframe_ps2keys.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtframe_ps2keys;

  localparam int TOUT_W = 4;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       ps2_valid;
  logic [7:0] ps2_byte;
  logic [9:0] key_joy1;
  logic [9:0] key_joy2;
  logic [3:0] key_start;
  logic [3:0] key_coin;
  logic       key_service;
  logic       key_test;
  logic       key_pause;
  logic       key_reset;

  int errors = 0;
  int checks = 0;

  jtframe_ps2keys #(.TOUT_W(TOUT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .ps2_valid   (ps2_valid),
    .ps2_byte    (ps2_byte),
    .key_joy1    (key_joy1),
    .key_joy2    (key_joy2),
    .key_start   (key_start),
    .key_coin    (key_coin),
    .key_service (key_service),
    .key_test    (key_test),
    .key_pause   (key_pause),
    .key_reset   (key_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs packed: {reset,pause,test,service,coin,start,joy2,joy1}
  function automatic logic [31:0] outs();
    return {key_reset, key_pause, key_test, key_service,
            key_coin, key_start, key_joy2, key_joy1};
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    obs = outs();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; returns at the negedge after it was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_valid = 1'b1;
    ps2_byte  = b;
    @(negedge clk);
    ps2_valid = 1'b0;
    ps2_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] pause_seq [8];

  initial begin
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    rst_n = 1'b0; clr = 1'b0; ps2_valid = 1'b0; ps2_byte = 8'h00;
    idle(3);
    check("reset_state", 32'h0000_0000);
    rst_n = 1'b1;
    idle(2);

    // Normal make / break of j1b4
    send(8'h14);            check("make_14", 32'h0000_0010);
    send(8'hF0);            check("f0_pending", 32'h0000_0010);
    send(8'h14);            check("break_14", 32'h0000_0000);

    // Extended up arrow
    send(8'hE0); send(8'h75);               check("ext_make_75", 32'h0000_0008);
    send(8'hE0); send(8'hF0); send(8'h75);  check("ext_break_75", 32'h0000_0000);

    // E0 14 is right-ctrl, not j1b4
    send(8'hE0); send(8'h14);               check("e0_14_ignored", 32'h0000_0000);
    send(8'hE0); send(8'hF0); send(8'h14);  check("e0_f0_14", 32'h0000_0000);

    // Pause sequence swallowed while j1b5 is held
    send(8'h11);            check("make_11", 32'h0000_0020);
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      check("pause_seq", 32'h0000_0020);
    end
    send(8'h16);            check("start1_after_pause", 32'h0010_0020);
    send(8'hF0); send(8'h11); send(8'hF0); send(8'h16);
    check("release_11_16", 32'h0000_0000);

    // E0 prefix survives a short gap
    send(8'hE0); idle(5); send(8'h74);      check("ext_short_gap", 32'h0000_0001);
    send(8'hE0); send(8'hF0); send(8'h74);  check("ext_break_74", 32'h0000_0000);

    // E0 prefix abandoned after timeout: 74 decodes as unmapped normal code
    send(8'hE0); idle(2**TOUT_W); send(8'h74);
    check("ext_timeout", 32'h0000_0000);

    // F0 prefix abandoned after timeout: 22 becomes a repeated make
    send(8'h22);            check("make_22", 32'h0000_0200);
    send(8'hF0); idle(2**TOUT_W); send(8'h22);
    check("brk_timeout", 32'h0000_0200);
    send(8'hF0); send(8'h22);               check("break_22", 32'h0000_0000);

    // Overrun byte 00 clears held keys
    send(8'h16); send(8'h2E);               check("hold_start_coin", 32'h0110_0000);
    send(8'h00);            check("overrun_00", 32'h0000_0000);

    // Overrun byte FF, with the pause key held
    send(8'h4D);            check("make_pause", 32'h4000_0000);
    send(8'hFF);            check("overrun_ff", 32'h0000_0000);

    // ACK byte ignored; service held; typematic repeat keeps bit set
    send(8'h46); send(8'hFA); send(8'h46);  check("ack_ignored", 32'h1000_0000);
    send(8'hF0); send(8'h46);               check("break_46", 32'h0000_0000);

    // Test and reset keys
    send(8'h06); send(8'h04);               check("test_reset_keys", 32'hA000_0000);
    send(8'hF0); send(8'h06); send(8'hF0); send(8'h04);
    check("release_test_reset", 32'h0000_0000);

    // clr wins over a coincident byte
    send(8'h16);            check("hold_16", 32'h0010_0000);
    @(negedge clk);
    clr = 1'b1; ps2_valid = 1'b1; ps2_byte = 8'h1E;
    @(negedge clk);
    clr = 1'b0; ps2_valid = 1'b0; ps2_byte = 8'h00;
    check("clr_priority", 32'h0000_0000);
    send(8'h1E);            check("after_clr_1e", 32'h0020_0000);
    send(8'hF0); send(8'h1E);               check("break_1e", 32'h0000_0000);

    // Opposite directions held together
    send(8'h1C); send(8'h23);
    checks++;
    assert (key_joy2[1:0] === 2'b11) else begin
      errors++;
      $error("FAIL joy2_lr: observed %b expected 11", key_joy2[1:0]);
    end
    check("joy2_lr_full", 32'h0000_0C00);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);
    check("release_joy2", 32'h0000_0000);

    // Reset in the middle of an F0 prefix
    send(8'h06);            check("hold_test", 32'h2000_0000);
    send(8'hF0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);         check("reset_mid_f0", 32'h0000_0000);
    rst_n = 1'b1;
    send(8'h22);            check("make_after_reset", 32'h0000_0200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
